// File: rtl/sb_rx_deframer_if.sv
// Sideband receive bus: serial line in, de-framed payload bytes and frame strobes out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the consumer must accept every strobe in the cycle it is asserted.
interface sb_rx_deframer_if #(
    parameter int MAX_PAYLOAD = 32
);
    localparam int CW = $clog2(MAX_PAYLOAD + 1);

    logic          sbrx;
    logic [7:0]    rx_byte;
    logic          rx_byte_valid;
    logic          frame_start;
    logic          frame_is_cmd;
    logic          frame_end;
    logic          frame_err;
    logic [CW-1:0] byte_count;

    modport master (
        input  sbrx,
        output rx_byte, rx_byte_valid, frame_start, frame_is_cmd,
               frame_end, frame_err, byte_count
    );

    modport slave (
        output sbrx,
        input  rx_byte, rx_byte_valid, frame_start, frame_is_cmd,
               frame_end, frame_err, byte_count
    );
endinterface

// File: rtl/sb_rx_deframer.sv
// Sideband RX deframer: 10-bit UART symbols -> DLE/STX/ETX de-framed, de-stuffed payload bytes.
// Latency: strobes 1 cycle after the stop bit (10 cycles after the start bit).
// Backpressure: none; strobes are one cycle wide and must be consumed when asserted.
module sb_rx_deframer #(
    parameter int         MAX_PAYLOAD = 32,
    parameter logic [7:0] DLE         = 8'hFE,
    parameter logic [7:0] STX_CMD     = 8'h05,
    parameter logic [7:0] STX_RSP     = 8'h04,
    parameter logic [7:0] ETX         = 8'h40
) (
    input  logic               sb_clk,
    input  logic               rst,
    sb_rx_deframer_if.master   bus
);
    localparam int CW = $clog2(MAX_PAYLOAD + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP, S_WAIT} sym_state_t;
    typedef enum logic [1:0] {F_IDLE, F_DLE1, F_PAY, F_PAY_DLE} frm_state_t;

    sym_state_t    sym_state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    sym_byte;
    logic          sym_done;
    logic          sym_bad;

    frm_state_t    frm_state;
    logic [7:0]    rx_byte;
    logic          rx_byte_valid;
    logic          frame_start;
    logic          frame_is_cmd;
    logic          frame_end;
    logic          frame_err;
    logic [CW-1:0] byte_count;

    logic          emit_req;
    logic          at_max;

    // Symbol recovery: one sample per sb_clk, LSB first, stop must be high.
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            sym_state <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            sym_byte  <= '0;
            sym_done  <= 1'b0;
            sym_bad   <= 1'b0;
        end else begin
            sym_done <= 1'b0;
            sym_bad  <= 1'b0;
            case (sym_state)
                S_IDLE: begin
                    if (!bus.sbrx) begin
                        sym_state <= S_DATA;
                        bit_cnt   <= '0;
                    end
                end
                S_DATA: begin
                    shreg <= {bus.sbrx, shreg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        sym_state <= S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                S_STOP: begin
                    sym_byte <= shreg;
                    if (bus.sbrx) begin
                        sym_done  <= 1'b1;
                        sym_state <= S_IDLE;
                    end else begin
                        sym_bad   <= 1'b1;
                        sym_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.sbrx) begin
                        sym_state <= S_IDLE;
                    end
                end
                default: sym_state <= S_IDLE;
            endcase
        end
    end

    // A stuffed DLE pair emits the DLE value itself, so the emitted byte is always sym_byte.
    always_comb begin
        emit_req = 1'b0;
        if (sym_done) begin
            emit_req = ((frm_state == F_PAY) && (sym_byte != DLE)) ||
                       ((frm_state == F_PAY_DLE) && (sym_byte == DLE));
        end
        at_max = (byte_count == CW'(MAX_PAYLOAD));
    end

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            frm_state     <= F_IDLE;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            frame_start   <= 1'b0;
            frame_is_cmd  <= 1'b0;
            frame_end     <= 1'b0;
            frame_err     <= 1'b0;
            byte_count    <= '0;
        end else begin
            rx_byte_valid <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            frame_err     <= 1'b0;
            if (sym_bad) begin
                if ((frm_state == F_PAY) || (frm_state == F_PAY_DLE)) begin
                    frame_err <= 1'b1;
                end
                frm_state <= F_IDLE;
            end else if (emit_req) begin
                if (at_max) begin
                    frame_err <= 1'b1;
                    frm_state <= F_IDLE;
                end else begin
                    rx_byte       <= sym_byte;
                    rx_byte_valid <= 1'b1;
                    byte_count    <= byte_count + CW'(1);
                    frm_state     <= F_PAY;
                end
            end else if (sym_done) begin
                case (frm_state)
                    F_IDLE: begin
                        if (sym_byte == DLE) frm_state <= F_DLE1;
                    end
                    F_DLE1: begin
                        if ((sym_byte == STX_CMD) || (sym_byte == STX_RSP)) begin
                            frm_state    <= F_PAY;
                            frame_start  <= 1'b1;
                            frame_is_cmd <= (sym_byte == STX_CMD);
                            byte_count   <= '0;
                        end else if (sym_byte != DLE) begin
                            frm_state <= F_IDLE;
                        end
                    end
                    F_PAY: begin
                        frm_state <= F_PAY_DLE;
                    end
                    F_PAY_DLE: begin
                        if (sym_byte == ETX) begin
                            frame_end <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        frm_state <= F_IDLE;
                    end
                    default: frm_state <= F_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_byte       = rx_byte;
    assign bus.rx_byte_valid = rx_byte_valid;
    assign bus.frame_start   = frame_start;
    assign bus.frame_is_cmd  = frame_is_cmd;
    assign bus.frame_end     = frame_end;
    assign bus.frame_err     = frame_err;
    assign bus.byte_count    = byte_count;
endmodule

// File: doc/sb_rx_deframer.md
# sb_rx_deframer

Sideband receive deframer between the electrical layer's `sbrx` line and the logical layer's sideband transaction handling. It recovers 10-bit UART-style symbols from the bit-synchronous `sbrx` stream clocked by `sb_clk`, strips DLE/STX/ETX framing and DLE byte-stuffing, and emits payload bytes with frame start/end/error strobes.

## Interface
- `MAX_PAYLOAD`, 32: maximum payload bytes per transaction (1..255).
- `DLE`, 8'hFE: framing escape byte.
- `STX_CMD`, 8'h05: start-of-command marker, follows DLE.
- `STX_RSP`, 8'h04: start-of-response marker, follows DLE.
- `ETX`, 8'h40: end-of-transaction marker, follows DLE.

Ports:
- `sb_clk`  in  1  sideband clock, one bit per cycle, rising edge. One clock only.
- `rst`  in  1  asynchronous, active-low reset.
- `sbrx`  in  1  serial sideband receive line; idle high.
- `rx_byte`  out  8  de-stuffed payload byte.
- `rx_byte_valid`  out  1  one-cycle strobe; `rx_byte` valid.
- `frame_start`  out  1  one-cycle strobe on DLE+STX accepted.
- `frame_is_cmd`  out  1  1 = command (STX_CMD), 0 = response; latched at `frame_start`.
- `frame_end`  out  1  one-cycle strobe on DLE+ETX.
- `frame_err`  out  1  one-cycle strobe; current frame aborted.
- `byte_count`  out  $clog2(MAX_PAYLOAD+1)  payload bytes emitted in current/last frame.

## Operation
- Symbol FSM (`S_IDLE`, `S_DATA`, `S_STOP`):
  - `S_IDLE`: `sbrx`==0 sampled → start bit, go `S_DATA`, bit counter = 0.
  - `S_DATA`: shift `sbrx` into the byte LSB first; after 8 samples go `S_STOP`.
  - `S_STOP`: `sbrx`==1 → internal `sym_done`; `sbrx`==0 → internal `sym_bad`, go `S_WAIT` (hold until `sbrx`==1, then `S_IDLE`); otherwise → `S_IDLE`.
  - Next start bit is accepted on the cycle immediately after the stop bit (back-to-back symbols, no idle gap required).
- Frame FSM (`F_IDLE`, `F_DLE1`, `F_PAY`, `F_PAY_DLE`), advances only on `sym_done`/`sym_bad`:
  - `F_IDLE`: DLE → `F_DLE1`; any other byte discarded.
  - `F_DLE1`: STX_CMD/STX_RSP → `F_PAY`, pulse `frame_start`, set `frame_is_cmd`, clear `byte_count`; DLE → stay; else → `F_IDLE`.
  - `F_PAY`: DLE → `F_PAY_DLE`; else emit byte.
  - `F_PAY_DLE`: DLE → emit 8'hFE, `F_PAY`; ETX → pulse `frame_end`, `F_IDLE`; else → `frame_err`, `F_IDLE`.
  - Emit = drive `rx_byte`, pulse `rx_byte_valid`, `byte_count`+1. Emit attempted when `byte_count`==MAX_PAYLOAD → no emit, `frame_err`, `F_IDLE`.
  - `sym_bad` in `F_PAY`/`F_PAY_DLE` → `frame_err`, `F_IDLE`; in `F_IDLE`/`F_DLE1` → `F_IDLE`, no error.
- At most one of `rx_byte_valid`/`frame_start`/`frame_end`/`frame_err` asserted per cycle.
- `byte_count`, `frame_is_cmd` hold after `frame_end`/`frame_err` until next `frame_start`.
- Zero-length frames (DLE STX DLE ETX) legal: `frame_end` with `byte_count`=0.

## Timing
- Reset (async assert, sync deassert by `sb_clk` recommended upstream): all FSMs to `S_IDLE`/`F_IDLE`; all outputs 0; `rx_byte`=0, `byte_count`=0.
- Symbol with start sampled at edge N: data at edges N+1..N+8, stop at N+9, `sym_done` registered at N+9, output strobes registered at edge N+10 (latency 10 cycles from start bit, 1 cycle after stop bit).
- Strobes are exactly one cycle wide.
- Reset asserted mid-symbol or mid-frame: partial byte and frame dropped, no strobe on release; first `sbrx`==0 after release is a start bit.
- Line held low continuously: one `sym_bad` (byte 0x00, stop 0), then `S_WAIT` until high; no repeated errors.

## Test plan
- Reset then idle `sbrx`=1 for 100 cycles → all outputs 0, no strobes.
- Send FE 05 11 22 FE 40 back-to-back → `frame_start` with `frame_is_cmd`=1; `rx_byte_valid` with 0x11 then 0x22; `frame_end` with `byte_count`=2; `rx_byte_valid` 1 cycle after each stop bit.
- Send FE 04 FE FE 33 FE 40 → `frame_is_cmd`=0; bytes 0xFE, 0x33; `frame_end`, `byte_count`=2.
- Send FE 05 AA, then AB with stop bit 0 → 0xAA emitted, `frame_err` 1 cycle after bad stop, no `frame_end`; following FE 05 FE 40 → clean zero-length frame.
- MAX_PAYLOAD=32: FE 05 + 33 bytes 0x01 → 32 `rx_byte_valid`, `frame_err` on 33rd, `byte_count`=32; trailing FE 40 produces no `frame_end`.
- Assert `rst` mid-payload after 3 bytes → outputs 0 immediately; FE 05 77 FE 40 afterwards → one byte 0x77, `byte_count`=1.
